// File: rtl/sh7034_int_seq_pkg.sv
// ---------------------------------------------------------------------------
// SH7034_PKG
// Shared definitions for the SH7034 interrupt acceptance sequencer.
//   seq_state_t   : sequencer FSM states
//   VEC_NMI       : vector number of the non-maskable interrupt
//   VEC_ADDR_ERR  : vector number used when the vector fetch times out
//   exc_mask_f()  : mask level handed to the CPU for an accepted interrupt
// ---------------------------------------------------------------------------
package SH7034_PKG;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACK   = 3'd1,
      ST_VREQ  = 3'd2,
      ST_FETCH = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } seq_state_t;

   localparam logic [7:0] VEC_NMI      = 8'd11;
   localparam logic [7:0] VEC_ADDR_ERR = 8'd9;

   // NMI always raises the CPU mask to the maximum level.
   function automatic logic [3:0] exc_mask_f(input logic [3:0] lvl,
                                             input logic [7:0] vec);
      return (vec == VEC_NMI) ? 4'hF : lvl;
   endfunction

endpackage

// File: rtl/sh7034_int_seq.sv
// ---------------------------------------------------------------------------
// sh7034_int_seq
// Interrupt acceptance sequencer: acknowledges the INTC, obtains the vector,
// fetches the handler address from the vector table at VBR and hands the
// exception (PC + new mask) to the CPU.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   CE_R, CE_F            rise / fall clock enables
//   INT_REQ/LVL/VEC       request, level and vector from the INTC
//   INT_MASK              mask level presented to the INTC
//   INT_ACK, INT_ACP      acknowledge pulse, accept pulse
//   VECT_REQ, VECT_WAIT   vector handshake with the INTC
//   SR_I, VBR, CPU_SLOT   CPU mask, vector base, instruction boundary
//   IBUS_*                bus master used for the vector-table read
//   EXC_VALID/PC/MASK     exception handoff, consumed by EXC_TAKEN
//
// Configuration
//   SH7034_INT_SEQ_BUSTO_EN : when defined, a WAIT-state timeout of
//   BUSTO_LIMIT CE_R cycles refetches the address-error vector once and, on
//   a second timeout, completes with EXC_PC = 0.
// ---------------------------------------------------------------------------
module sh7034_int_seq
   import SH7034_PKG::*;
#(
   parameter logic [7:0] BUSTO_LIMIT = 8'd255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        INT_REQ,
   input  logic [3:0]  INT_LVL,
   input  logic [7:0]  INT_VEC,
   output logic [3:0]  INT_MASK,
   output logic        INT_ACK,
   output logic        INT_ACP,
   output logic        VECT_REQ,
   input  logic        VECT_WAIT,
   input  logic [3:0]  SR_I,
   input  logic [31:0] VBR,
   input  logic        CPU_SLOT,
   output logic [27:0] IBUS_A,
   output logic [3:0]  IBUS_BA,
   output logic        IBUS_WE,
   output logic        IBUS_REQ,
   input  logic [31:0] IBUS_DI,
   input  logic        IBUS_BUSY,
   output logic        EXC_VALID,
   output logic [31:0] EXC_PC,
   output logic [3:0]  EXC_MASK,
   input  logic        EXC_TAKEN
);

   seq_state_t  state_reg, state_next;
   logic [3:0]  lvl_reg;
   logic [7:0]  vec_reg;
   logic [31:0] exc_pc_reg;
   logic        acp_reg;
   logic        accept, capture, enter_done, bus_phase;
   logic [31:0] fetch_addr;

`ifdef SH7034_INT_SEQ_BUSTO_EN
   logic [7:0]  busto_cnt_reg;
   logic        busto_retry_reg;
   logic        busto_gap_reg;
   logic        busto_refetch, busto_fail;
`endif

   // Vector table entry address; wraps modulo 2^32 before truncation.
   assign fetch_addr = VBR + {22'd0, vec_reg, 2'b00};
   assign bus_phase  = (state_reg == ST_FETCH) || (state_reg == ST_WAIT);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      capture    = 1'b0;
`ifdef SH7034_INT_SEQ_BUSTO_EN
      busto_refetch = 1'b0;
      busto_fail    = 1'b0;
`endif
      case (state_reg)
         ST_IDLE:  if (CE_R && INT_REQ && CPU_SLOT) begin
                      state_next = ST_ACK;
                      accept     = 1'b1;
                   end
         ST_ACK:   if (CE_R) state_next = ST_VREQ;
         ST_VREQ:  if (CE_R && VECT_WAIT) state_next = ST_FETCH;
         ST_FETCH: if (CE_R) state_next = ST_WAIT;
         ST_WAIT: begin
            // The bus is sampled on the fall enable; a completed read
            // takes priority over a timeout landing on the same clock.
            if (CE_F && !IBUS_BUSY) begin
               state_next = ST_DONE;
               capture    = 1'b1;
            end
`ifdef SH7034_INT_SEQ_BUSTO_EN
            else if (CE_R && (busto_cnt_reg == BUSTO_LIMIT - 8'd1)) begin
               if (!busto_retry_reg) begin
                  state_next    = ST_FETCH;
                  busto_refetch = 1'b1;
               end else begin
                  state_next = ST_DONE;
                  busto_fail = 1'b1;
               end
            end
`endif
         end
         ST_DONE:  if (CE_R && EXC_TAKEN) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      enter_done = (state_next == ST_DONE) && (state_reg != ST_DONE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lvl_reg    <= '0;
         vec_reg    <= '0;
         exc_pc_reg <= '0;
         acp_reg    <= 1'b0;
      end else begin
         if (accept) begin
            lvl_reg <= INT_LVL;
            vec_reg <= INT_VEC;
         end
         if (capture) exc_pc_reg <= IBUS_DI;
`ifdef SH7034_INT_SEQ_BUSTO_EN
         if (busto_refetch) vec_reg    <= VEC_ADDR_ERR;
         if (busto_fail)    exc_pc_reg <= '0;
`endif
         // DONE may be entered on a fall enable; the accept pulse then
         // lasts until the following rise enable.
         if (enter_done) acp_reg <= 1'b1;
         else if (CE_R)  acp_reg <= 1'b0;
      end
   end

`ifdef SH7034_INT_SEQ_BUSTO_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busto_cnt_reg   <= '0;
         busto_retry_reg <= 1'b0;
         busto_gap_reg   <= 1'b0;
      end else begin
         // One-clock request gap so the bus sees the refetch as a new cycle.
         busto_gap_reg <= busto_refetch;
         if (state_reg == ST_FETCH)              busto_cnt_reg <= '0;
         else if (state_reg == ST_WAIT && CE_R)  busto_cnt_reg <= busto_cnt_reg + 8'd1;
         if (accept)             busto_retry_reg <= 1'b0;
         else if (busto_refetch) busto_retry_reg <= 1'b1;
      end
   end
   assign IBUS_REQ = bus_phase && !busto_gap_reg;
`else
   assign IBUS_REQ = bus_phase;
`endif

   // Any state past IDLE raises the mask to block nested requests.
   assign INT_MASK  = (state_reg == ST_IDLE) ? SR_I : 4'hF;
   assign INT_ACK   = (state_reg == ST_ACK);
   assign INT_ACP   = (state_reg == ST_DONE) && acp_reg;
   assign VECT_REQ  = (state_reg == ST_VREQ);
   assign IBUS_WE   = 1'b0;
   assign IBUS_BA   = bus_phase ? 4'hF : 4'h0;
   assign IBUS_A    = bus_phase ? fetch_addr[27:0] : 28'd0;
   assign EXC_VALID = (state_reg == ST_DONE);
   assign EXC_MASK  = (state_reg == ST_DONE) ? exc_mask_f(lvl_reg, vec_reg) : 4'h0;
   assign EXC_PC    = exc_pc_reg;

endmodule

// File: tb/tb_sh7034_int_seq.sv
module tb_sh7034_int_seq;

   logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b0, CE_F = 1'b0;
   logic        INT_REQ = 1'b0, VECT_WAIT = 1'b0, CPU_SLOT = 1'b0;
   logic [3:0]  INT_LVL = '0, SR_I = '0;
   logic [7:0]  INT_VEC = '0;
   logic [31:0] VBR = '0, IBUS_DI = '0;
   logic        IBUS_BUSY = 1'b0, EXC_TAKEN = 1'b0;
   logic [3:0]  INT_MASK, IBUS_BA, EXC_MASK;
   logic        INT_ACK, INT_ACP, VECT_REQ, IBUS_WE, IBUS_REQ, EXC_VALID;
   logic [27:0] IBUS_A;
   logic [31:0] EXC_PC;

   int vectors = 0, miscompares = 0;

   sh7034_int_seq #(.BUSTO_LIMIT(8'd4)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
      .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
      .INT_MASK(INT_MASK), .INT_ACK(INT_ACK), .INT_ACP(INT_ACP),
      .VECT_REQ(VECT_REQ), .VECT_WAIT(VECT_WAIT),
      .SR_I(SR_I), .VBR(VBR), .CPU_SLOT(CPU_SLOT),
      .IBUS_A(IBUS_A), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
      .IBUS_DI(IBUS_DI), .IBUS_BUSY(IBUS_BUSY),
      .EXC_VALID(EXC_VALID), .EXC_PC(EXC_PC), .EXC_MASK(EXC_MASK), .EXC_TAKEN(EXC_TAKEN)
   );

   initial forever #5 CLK = ~CLK;

   // Rise and fall enables alternate on successive clock edges.
   initial begin
      bit ph = 1'b0;
      forever begin
         @(posedge CLK); #2;
         ph = ~ph; CE_R = ph; CE_F = ~ph;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
      $fatal(1, "watchdog");
   end

   // Bus/handshake observer: counts pulses in rise-enable cycles and records
   // the addresses driven while a request is active.
   int ack_cer, acp_cer, req_cer, ack_rises, acp_rises, req_rises, bus_bad;
   logic [27:0] first_addr, last_addr;
   logic ack_p = 0, acp_p = 0, req_p = 0;
   initial forever begin
      @(negedge CLK);
      if (CE_R) begin
         if (INT_ACK)  ack_cer++;
         if (INT_ACP)  acp_cer++;
         if (IBUS_REQ) req_cer++;
      end
      if (INT_ACK && !ack_p) ack_rises++;
      if (INT_ACP && !acp_p) acp_rises++;
      if (IBUS_REQ && !req_p) begin
         if (req_rises == 0) first_addr = IBUS_A;
         req_rises++;
      end
      if (IBUS_REQ) begin
         last_addr = IBUS_A;
         if (IBUS_WE !== 1'b0 || IBUS_BA !== 4'hF) bus_bad++;
      end
      ack_p = INT_ACK; acp_p = INT_ACP; req_p = IBUS_REQ;
   end

   task automatic clr_mon();
      ack_cer = 0; acp_cer = 0; req_cer = 0; ack_rises = 0; acp_rises = 0;
      req_rises = 0; bus_bad = 0; first_addr = '0; last_addr = '0;
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic tmo(input string what);
      vectors++; miscompares++;
      $display("FAIL %s: wait expired, got no event, need event", what);
   endtask

   task automatic wait_f();
      int n = 0;
      do begin step(); n++; end while (!CE_F && n < 10);
   endtask

   // Reference model: vector-table address and handed-over mask.
   function automatic logic [27:0] m_addr(input logic [31:0] vbr, input logic [7:0] vec);
      longint unsigned s;
      s = (longint'(vbr) + longint'(vec) * 4) % 64'h1_0000_0000;
      return s[27:0];
   endfunction
   function automatic logic [3:0] m_mask(input logic [3:0] lvl, input logic [7:0] vec);
      return (vec == 8'd11) ? 4'hF : lvl;
   endfunction

   // Plays the INTC and bus slave for one full interrupt acceptance.
   // busy: number of fall-enable samples with BUSY high (255 = stuck).
   task automatic run_txn(input logic [31:0] vbr, input logic [3:0] lvl,
                          input logic [7:0] vec, input logic [31:0] di,
                          input int busy, input bit hold_req,
                          output logic [31:0] o_pc, output logic [3:0] o_mask,
                          output logic [3:0] o_imask);
      int n;
      o_pc = '0; o_mask = '0; o_imask = '0;
      VBR = vbr; INT_LVL = lvl; INT_VEC = vec; IBUS_DI = di;
      IBUS_BUSY = (busy != 0); SR_I = 4'($urandom); CPU_SLOT = 1'b1;
      clr_mon(); INT_REQ = 1'b1;
      n = 0; do begin step(); n++; end while (!INT_ACK && n < 20);
      if (!INT_ACK) begin tmo("ack_wait"); INT_REQ = 1'b0; return; end
      o_imask = INT_MASK;
      if (!hold_req) begin
         // Latched values must survive the INTC changing its outputs.
         INT_REQ = 1'b0; INT_LVL = 4'($urandom); INT_VEC = 8'($urandom);
         CPU_SLOT = 1'($urandom);
      end
      n = 0; do begin step(); n++; end while (!VECT_REQ && n < 20);
      if (!VECT_REQ) begin tmo("vreq_wait"); return; end
      repeat ($urandom_range(0, 3)) step();
      VECT_WAIT = 1'b1;
      n = 0; do begin step(); n++; end while (VECT_REQ && n < 20);
      VECT_WAIT = 1'b0;
      if (VECT_REQ) begin tmo("vreq_drop"); return; end
      if (busy > 0 && busy < 255) begin
         repeat (busy + 1) wait_f();
         IBUS_BUSY = 1'b0;
      end
      n = 0; do begin step(); n++; end while (!EXC_VALID && n < 200);
      if (!EXC_VALID) begin tmo("exc_valid"); IBUS_BUSY = 1'b0; return; end
      o_pc = EXC_PC; o_mask = EXC_MASK;
      if (hold_req) CPU_SLOT = 1'b1;
      repeat ($urandom_range(0, 2)) step();
      EXC_TAKEN = 1'b1;
      n = 0; do begin step(); n++; end while (EXC_VALID && n < 20);
      EXC_TAKEN = 1'b0; IBUS_BUSY = 1'b0;
      if (EXC_VALID) tmo("exc_taken");
   endtask

   task automatic test_reset();
      logic [3:0] s;
      SR_I = 4'($urandom_range(1, 15)); #1;
      vectors++;
      if (INT_MASK !== SR_I) begin miscompares++;
         $display("FAIL rst_int_mask: got %h, need %h", INT_MASK, SR_I); end
      vectors++;
      if ({INT_ACK, INT_ACP, VECT_REQ, IBUS_REQ, IBUS_WE, EXC_VALID} !== 6'b0) begin miscompares++;
         $display("FAIL rst_strobes: got %b, need 000000",
                  {INT_ACK, INT_ACP, VECT_REQ, IBUS_REQ, IBUS_WE, EXC_VALID}); end
      vectors++;
      if ({IBUS_A, IBUS_BA, EXC_MASK} !== 36'd0) begin miscompares++;
         $display("FAIL rst_bus: got A=%h BA=%h M=%h, need 0", IBUS_A, IBUS_BA, EXC_MASK); end
      vectors++;
      if (EXC_PC !== 32'd0) begin miscompares++;
         $display("FAIL rst_exc_pc: got %h, need 0", EXC_PC); end
      s = ~SR_I; SR_I = s; #1;
      vectors++;
      if (INT_MASK !== s) begin miscompares++;
         $display("FAIL rst_mask_follow: got %h, need %h", INT_MASK, s); end
      $display("reset: INT_MASK=%h EXC_PC=%h", INT_MASK, EXC_PC);
      @(negedge CLK); RST_N = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_slot();
      int acks = 0;
      CPU_SLOT = 1'b0; INT_REQ = 1'b1;
      repeat (6) begin step(); if (INT_ACK) acks++; end
      INT_REQ = 1'b0; CPU_SLOT = 1'b1;
      vectors++;
      if (acks !== 0) begin miscompares++;
         $display("FAIL slot_block: got %0d ack cycles, need 0", acks); end
      $display("slot: no boundary, ack cycles=%0d", acks);
   endtask

   task automatic test_basic();
      logic [31:0] di, pc; logic [3:0] m, im;
      di = $urandom | 32'h1;
      run_txn(32'h0, 4'd5, 8'd64, di, 0, 1'b0, pc, m, im);
      $display("basic: A=%h PC=%h MASK=%h ack=%0d acp=%0d", first_addr, pc, m, ack_rises, acp_rises);
      vectors++; if (first_addr !== 28'h100) begin miscompares++;
         $display("FAIL basic_addr: got %h, need 0000100", first_addr); end
      vectors++; if (pc !== di) begin miscompares++;
         $display("FAIL basic_pc: got %h, need %h", pc, di); end
      vectors++; if (m !== 4'd5) begin miscompares++;
         $display("FAIL basic_mask: got %h, need 5", m); end
      vectors++; if (ack_rises !== 1 || ack_cer !== 1) begin miscompares++;
         $display("FAIL basic_ack: got %0d pulses/%0d cycles, need 1/1", ack_rises, ack_cer); end
      vectors++; if (acp_rises !== 1 || acp_cer !== 1) begin miscompares++;
         $display("FAIL basic_acp: got %0d pulses/%0d cycles, need 1/1", acp_rises, acp_cer); end
      vectors++; if (im !== 4'hF) begin miscompares++;
         $display("FAIL basic_busy_mask: got %h, need F", im); end
      vectors++; if (bus_bad !== 0) begin miscompares++;
         $display("FAIL basic_bus_ctl: got %0d bad cycles, need 0", bus_bad); end
      vectors++; if (INT_MASK !== SR_I) begin miscompares++;
         $display("FAIL basic_idle_mask: got %h, need %h", INT_MASK, SR_I); end
   endtask

   task automatic test_nmi();
      logic [31:0] pc, vbr; logic [3:0] m, im;
      vbr = $urandom;
      run_txn(vbr, 4'd0, 8'd11, $urandom, 0, 1'b0, pc, m, im);
      $display("nmi: A=%h MASK=%h", first_addr, m);
      vectors++; if (m !== 4'hF) begin miscompares++;
         $display("FAIL nmi_mask: got %h, need F", m); end
      vectors++; if (first_addr !== m_addr(vbr, 8'd11)) begin miscompares++;
         $display("FAIL nmi_addr: got %h, need %h", first_addr, m_addr(vbr, 8'd11)); end
   endtask

   task automatic test_wrap();
      logic [31:0] pc, di; logic [3:0] m, im;
      di = $urandom;
      run_txn(32'hFFFF_FFF0, 4'd3, 8'd8, di, 0, 1'b0, pc, m, im);
      $display("wrap: A=%h PC=%h", first_addr, pc);
      vectors++; if (first_addr !== 28'h0000010) begin miscompares++;
         $display("FAIL wrap_addr: got %h, need 0000010", first_addr); end
      vectors++; if (pc !== di) begin miscompares++;
         $display("FAIL wrap_pc: got %h, need %h", pc, di); end
   endtask

   task automatic test_busy();
      logic [31:0] pc, di; logic [3:0] m, im;
      di = $urandom;
      run_txn(32'h0000_4000, 4'd7, 8'd70, di, 3, 1'b0, pc, m, im);
      $display("busy3: req cycles=%0d PC=%h", req_cer, pc);
      vectors++; if (req_cer !== 4) begin miscompares++;
         $display("FAIL busy_req_len: got %0d, need 4", req_cer); end
      vectors++; if (pc !== di) begin miscompares++;
         $display("FAIL busy_pc: got %h, need %h", pc, di); end
   endtask

   task automatic test_random();
      logic [31:0] pc, di, vbr; logic [3:0] m, im, lvl; logic [7:0] vec; int busy;
      for (int i = 0; i < 16; i++) begin
         vbr = $urandom; di = $urandom; lvl = 4'($urandom);
         vec = ($urandom_range(0, 3) == 0) ? 8'd11 : 8'($urandom);
         busy = $urandom_range(0, 4);
         run_txn(vbr, lvl, vec, di, busy, 1'b0, pc, m, im);
         $display("rand %0d: VBR=%h VEC=%0d LVL=%0d busy=%0d A=%h PC=%h MASK=%h",
                  i, vbr, vec, lvl, busy, first_addr, pc, m);
         vectors++;
         if (first_addr !== m_addr(vbr, vec) || pc !== di || m !== m_mask(lvl, vec)) begin
            miscompares++;
            $display("FAIL rand_result: got A=%h PC=%h M=%h, need A=%h PC=%h M=%h",
                     first_addr, pc, m, m_addr(vbr, vec), di, m_mask(lvl, vec));
         end
         vectors++;
         if (req_cer !== busy + 1 || ack_rises !== 1 || acp_rises !== 1) begin
            miscompares++;
            $display("FAIL rand_timing: got req=%0d ack=%0d acp=%0d, need req=%0d ack=1 acp=1",
                     req_cer, ack_rises, acp_rises, busy + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] pc, di; logic [3:0] m, im; int n;
      VBR = 32'h100; INT_VEC = 8'd20; INT_LVL = 4'd2; IBUS_BUSY = 1'b1;
      CPU_SLOT = 1'b1; SR_I = 4'($urandom); INT_REQ = 1'b1;
      n = 0; do begin step(); n++; end while (!INT_ACK && n < 20);
      INT_REQ = 1'b0;
      n = 0; do begin step(); n++; end while (!VECT_REQ && n < 20);
      VECT_WAIT = 1'b1;
      n = 0; do begin step(); n++; end while (!IBUS_REQ && n < 20);
      VECT_WAIT = 1'b0;
      if (!IBUS_REQ) tmo("mid_req");
      repeat (3) step();
      @(posedge CLK); #3; RST_N = 1'b0; #1;
      $display("reset mid: REQ=%b VREQ=%b PC=%h MASK=%h", IBUS_REQ, VECT_REQ, EXC_PC, INT_MASK);
      vectors++; if (IBUS_REQ !== 1'b0 || VECT_REQ !== 1'b0 || IBUS_BA !== 4'h0) begin miscompares++;
         $display("FAIL mid_drop: got REQ=%b VREQ=%b BA=%h, need 0 0 0", IBUS_REQ, VECT_REQ, IBUS_BA); end
      vectors++; if (EXC_PC !== 32'd0 || EXC_VALID !== 1'b0) begin miscompares++;
         $display("FAIL mid_exc: got PC=%h V=%b, need 0 0", EXC_PC, EXC_VALID); end
      vectors++; if (INT_MASK !== SR_I) begin miscompares++;
         $display("FAIL mid_mask: got %h, need %h", INT_MASK, SR_I); end
      @(negedge CLK); RST_N = 1'b1; IBUS_BUSY = 1'b0;
      step();
      di = $urandom;
      run_txn(32'h2000, 4'd9, 8'd33, di, 1, 1'b0, pc, m, im);
      $display("after reset: A=%h PC=%h MASK=%h", first_addr, pc, m);
      vectors++; if (first_addr !== m_addr(32'h2000, 8'd33) || pc !== di || m !== 4'd9) begin
         miscompares++;
         $display("FAIL mid_resume: got A=%h PC=%h M=%h, need A=%h PC=%h M=9",
                  first_addr, pc, m, m_addr(32'h2000, 8'd33), di); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc; logic [3:0] m, im; int n;
      run_txn(32'h0, 4'd4, 8'd50, $urandom, 0, 1'b1, pc, m, im);
      n = 0; do begin step(); n++; end while (!INT_ACK && n < 20);
      $display("back-to-back: clocks from IDLE to next ack=%0d", n);
      vectors++; if (n !== 2) begin miscompares++;
         $display("FAIL b2b_gap: got %0d clocks, need 2", n); end
      INT_REQ = 1'b0;
      @(negedge CLK); RST_N = 1'b0;
      @(negedge CLK); RST_N = 1'b1;
      step();
   endtask

`ifdef SH7034_INT_SEQ_BUSTO_EN
   task automatic test_busto();
      logic [31:0] pc; logic [3:0] m, im;
      run_txn(32'h0001_0000, 4'd6, 8'd40, 32'hDEAD_BEEF, 255, 1'b0, pc, m, im);
      $display("busto: first=%h refetch=%h rises=%0d PC=%h", first_addr, last_addr, req_rises, pc);
      vectors++; if (first_addr !== m_addr(32'h0001_0000, 8'd40) || last_addr !== m_addr(32'h0001_0000, 8'd9)) begin
         miscompares++;
         $display("FAIL busto_addr: got %h/%h, need %h/%h", first_addr, last_addr,
                  m_addr(32'h0001_0000, 8'd40), m_addr(32'h0001_0000, 8'd9)); end
      vectors++; if (pc !== 32'd0 || req_rises !== 2) begin miscompares++;
         $display("FAIL busto_result: got PC=%h rises=%0d, need 0 and 2", pc, req_rises); end
   endtask
`endif

   initial begin
      test_reset();
      test_slot();
      test_basic();
      test_nmi();
      test_wrap();
      test_busy();
      test_random();
      test_reset_mid();
      test_back_to_back();
`ifdef SH7034_INT_SEQ_BUSTO_EN
      test_busto();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sh7034_int_seq.md
SH7034_INT_SEQ -- requirements
Module: sh7034_int_seq

Interface
REQ-001 SHALL have parameter BUSTO_LIMIT, default 8'd255, the bus-timeout limit in CE_R cycles.
REQ-002 SHALL have ports CLK (in, 1, system clock) and RST_N (in, 1, async active-low reset). This is decided: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports CE_R (in, 1) and CE_F (in, 1): rise and fall clock enables.
REQ-004 SHALL have port INT_REQ (in, 1): request from the INTC.
REQ-005 SHALL have ports INT_LVL (in, 4) and INT_VEC (in, 8): the INTC's level and vector.
REQ-006 SHALL have port INT_MASK (out, 4): the mask level presented to the INTC.
REQ-007 SHALL have ports INT_ACK (out, 1) and INT_ACP (out, 1): acknowledge pulse and accept pulse.
REQ-008 SHALL have ports VECT_REQ (out, 1) and VECT_WAIT (in, 1): the vector handshake with the INTC.
REQ-009 SHALL have ports SR_I (in, 4, current CPU mask), VBR (in, 32) and CPU_SLOT (in, 1, instruction boundary).
REQ-010 SHALL have bus-master ports IBUS_A (out, 28), IBUS_BA (out, 4), IBUS_WE (out, 1), IBUS_REQ (out, 1), IBUS_DI (in, 32) and IBUS_BUSY (in, 1).
REQ-011 SHALL have ports EXC_VALID (out, 1), EXC_PC (out, 32), EXC_MASK (out, 4) and EXC_TAKEN (in, 1): the handoff to the CPU.

Function
REQ-012 SHALL update state only on CE_R, except that bus sampling in WAIT SHALL occur on CE_F.
REQ-013 SHALL implement FSM states IDLE, ACK, VREQ, FETCH, WAIT and DONE.
REQ-014 IDLE->ACK SHALL occur when INT_REQ && CPU_SLOT; in the same edge INT_LVL and INT_VEC SHALL be latched.
REQ-015 ACK SHALL assert INT_ACK for exactly one CE_R cycle, then go to VREQ.
REQ-016 VREQ SHALL hold VECT_REQ high until VECT_WAIT is sampled high, then drop VECT_REQ and go to FETCH.
REQ-017 FETCH SHALL drive IBUS_REQ=1, IBUS_WE=0, IBUS_BA=4'hF and IBUS_A=(VBR+{VEC,2'b00})[27:0]; the 32-bit add SHALL wrap modulo 2^32. FETCH SHALL then go to WAIT.
REQ-018 WAIT SHALL keep IBUS_REQ high while IBUS_BUSY=1; at the first CE_F with IBUS_BUSY=0 it SHALL capture IBUS_DI into EXC_PC and go to DONE.
REQ-019 DONE SHALL assert EXC_VALID; EXC_MASK SHALL be the latched LVL, or 4'hF when VEC==11 (NMI).
REQ-020 DONE SHALL pulse INT_ACP for one CE_R cycle on entry.
REQ-021 DONE SHALL hold EXC_VALID until EXC_TAKEN=1, then go to IDLE.
REQ-022 INT_MASK SHALL equal SR_I in IDLE and 4'hF in every other state, which blocks nested requests.
REQ-023 If INT_REQ drops in ACK or later, the sequence SHALL complete with the latched values.
REQ-024 If INT_REQ and EXC_TAKEN coincide in DONE, IDLE SHALL be entered first; a new acceptance SHALL occur no earlier than the next CE_R.

Reset
REQ-025 On RST_N=0 the block SHALL go to IDLE and drive all outputs 0, except INT_MASK=SR_I and IBUS_BA=0.
REQ-026 On RST_N=0 EXC_PC SHALL be 0.
REQ-027 Reset mid-sequence SHALL abort immediately and SHALL drop IBUS_REQ and VECT_REQ in the same cycle.

Configuration
REQ-028 SH7034_INT_SEQ_BUSTO_EN SHALL compile in an 8-bit counter of CE_R cycles spent in WAIT.
REQ-029 With SH7034_INT_SEQ_BUSTO_EN, when the count reaches BUSTO_LIMIT the block SHALL drop IBUS_REQ, set VEC to 9 (address error) and re-enter FETCH once.
REQ-030 With SH7034_INT_SEQ_BUSTO_EN, a second timeout SHALL give EXC_PC=0 and go to DONE.
REQ-031 Without SH7034_INT_SEQ_BUSTO_EN, WAIT SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-032 The FSM state enum and the vector constants (NMI=11, ADDR_ERR=9) SHALL live in SH7034_PKG.
REQ-033 The block SHALL contain no sub-modules; the timeout counter SHALL be inline under the macro.

Verification
REQ-034 Scenario: VBR=0, INT_REQ with LVL=5, VEC=64, CPU_SLOT=1, no bus wait -> IBUS_A=0x100, EXC_PC=IBUS_DI, EXC_MASK=5, one INT_ACK and one INT_ACP.
REQ-035 Scenario: VEC=11 with LVL=0 -> EXC_MASK=4'hF.
REQ-036 Scenario: VBR=0xFFFFFFF0, VEC=8 -> the add wraps and IBUS_A=28'h0000010.
REQ-037 Scenario: IBUS_BUSY held 3 cycles -> IBUS_REQ stays high 4 cycles and EXC_PC is captured after BUSY falls.
REQ-038 Scenario: RST_N pulsed during WAIT -> IDLE, all outputs at reset values; a later INT_REQ is serviced normally.
REQ-039 Scenario: with SH7034_INT_SEQ_BUSTO_EN and BUSTO_LIMIT=4, IBUS_BUSY stuck high -> refetch at VBR+0x24, then EXC_VALID with EXC_PC=0.
